// File: rtl/neopixel_pkg.sv
// Shared constants and helpers for the NeoPixel frame sequencer:
// state encodings, default pixel width and the latch-period helper.
package neopixel_pkg;

  localparam int COLOUR_W = 32'sd24;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_LOAD    = 3'd2;
  localparam state_t ST_SEND    = 3'd3;
  localparam state_t ST_WAIT_HI = 3'd4;
  localparam state_t ST_WAIT_LO = 3'd5;
  localparam state_t ST_LATCH   = 3'd6;
  localparam state_t ST_DONE    = 3'd7;

  // Number of clk cycles the line must stay idle so the LEDs latch their colour.
  function automatic int latch_cycles(input int clk_hz, input int us);
    return (clk_hz / 32'sd1_000_000) * us;
  endfunction

endpackage

// File: rtl/neopixel_latch_timer.sv
// One-shot cycle timer: load arms it from zero, expire is high for the single
// cycle in which the count reaches CYCLES-1, after which it disarms.
module neopixel_latch_timer #(
  parameter int CYCLES = 32'sd960
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int CNT_W = (CYCLES > 32'sd1) ? $clog2(CYCLES) : 32'sd1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CYCLES - 32'sd1);

  logic [CNT_W-1:0] cnt_r;
  logic             armed_r;

  // expire is precomputed one cycle ahead so it is a clean registered pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      armed_r <= 1'b0;
      expire  <= 1'b0;
    end else if (load) begin
      cnt_r   <= {CNT_W{1'b0}};
      armed_r <= 1'b1;
      expire  <= (TERM == {CNT_W{1'b0}});
    end else if (armed_r) begin
      if (cnt_r == TERM) begin
        armed_r <= 1'b0;
        expire  <= 1'b0;
      end else begin
        cnt_r  <= cnt_r + CNT_W'(1'b1);
        expire <= ((cnt_r + CNT_W'(1'b1)) == TERM);
      end
    end else begin
      expire <= 1'b0;
    end
  end

endmodule

// File: rtl/neopixel_frame_sequencer.sv
// Streams NUM_PIXELS GRB words from the colour RAM to the single-bit writer, MSB
// first, then holds the line idle for the latch period and pulses frame_done.
module neopixel_frame_sequencer #(
  parameter int NUM_PIXELS = 32'sd8,
  parameter int COLOUR_W   = neopixel_pkg::COLOUR_W,
  parameter int CLK_HZ     = 32'sd12_000_000,
  parameter int LATCH_US   = 32'sd80,
  parameter int ADDR_W     = (NUM_PIXELS > 32'sd1) ? $clog2(NUM_PIXELS) : 32'sd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADDR_W-1:0]   pixel_addr,
  input  logic [COLOUR_W-1:0] pixel_data,
  output logic                bit_value,
  output logic                bit_valid,
  input  logic                bit_busy,
  output logic                frame_busy,
  output logic                frame_done
);

  import neopixel_pkg::*;

  localparam int LATCH_CYCLES = latch_cycles(CLK_HZ, LATCH_US);
  localparam int BIT_CNT_W    = $clog2(COLOUR_W);
  localparam logic [ADDR_W-1:0]    LAST_IDX = ADDR_W'(NUM_PIXELS - 32'sd1);
  localparam logic [BIT_CNT_W-1:0] TOP_BIT  = BIT_CNT_W'(COLOUR_W - 32'sd1);

  state_t                state_r;
  logic [ADDR_W-1:0]     pix_idx_r;
  logic [BIT_CNT_W-1:0]  bit_cnt_r;
  // MSB goes straight to bit_value on load; only the remaining bits are kept here
  logic [COLOUR_W-2:0]   remain_r;
  logic                  latch_load_s;
  logic                  latch_expire_s;

  // Last bit of the last pixel has been released by the writer.
  assign latch_load_s = (state_r == ST_WAIT_LO) && !bit_busy &&
                        (bit_cnt_r == {BIT_CNT_W{1'b0}}) && (pix_idx_r == LAST_IDX);

  neopixel_latch_timer #(
    .CYCLES (LATCH_CYCLES)
  ) u_latch_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (latch_load_s),
    .expire (latch_expire_s)
  );

  // Frame sequencing FSM; every output is a register written here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      pix_idx_r  <= {ADDR_W{1'b0}};
      bit_cnt_r  <= {BIT_CNT_W{1'b0}};
      remain_r   <= {(COLOUR_W-1){1'b0}};
      pixel_addr <= {ADDR_W{1'b0}};
      bit_value  <= 1'b0;
      bit_valid  <= 1'b0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_FETCH;
            pix_idx_r  <= {ADDR_W{1'b0}};
            pixel_addr <= {ADDR_W{1'b0}};
            frame_busy <= 1'b1;
          end
        end
        ST_FETCH: begin
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          remain_r  <= pixel_data[COLOUR_W-2:0];
          bit_cnt_r <= TOP_BIT;
          bit_value <= pixel_data[COLOUR_W-1];
          bit_valid <= 1'b1;
          state_r   <= ST_SEND;
        end
        ST_SEND: begin
          state_r <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (bit_busy) begin
            state_r <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (!bit_busy) begin
            if (bit_cnt_r != {BIT_CNT_W{1'b0}}) begin
              bit_value <= remain_r[COLOUR_W-2];
              remain_r  <= {remain_r[COLOUR_W-3:0], 1'b0};
              bit_cnt_r <= bit_cnt_r - BIT_CNT_W'(1'b1);
              bit_valid <= 1'b1;
              state_r   <= ST_SEND;
            end else if (pix_idx_r != LAST_IDX) begin
              pix_idx_r  <= pix_idx_r + ADDR_W'(1'b1);
              pixel_addr <= pix_idx_r + ADDR_W'(1'b1);
              state_r    <= ST_FETCH;
            end else begin
              state_r <= ST_LATCH;
            end
          end
        end
        ST_LATCH: begin
          if (latch_expire_s) begin
            frame_done <= 1'b1;
            frame_busy <= 1'b0;
            state_r    <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          frame_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Scoreboard bench: two sequencers (2 pixels and 1 pixel), each with a behavioural
// RAM and bit-writer model; expected bit streams come from the RAM words directly.
module tb_neopixel_frame_sequencer;

  localparam int CW        = 24;
  localparam int LATCH_CYC = (12_000_000 / 1_000_000) * 80;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int np, input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL [np=%0d] %s: got %0d, expected %0d", np, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int NP = (g == 0) ? 2 : 1;
    localparam int AW = (NP > 1) ? $clog2(NP) : 1;

    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          bit_busy = 1'b0;
    logic [AW-1:0] pixel_addr;
    logic [CW-1:0] pixel_data;
    logic          bit_value, bit_valid, frame_busy, frame_done;
    logic [CW-1:0] ram [NP];
    bit            exp_q [$];
    int            pending = 0;
    int            vcount = 0;
    int            last_fall = 0;
    bit            long_mode = 1'b0;
    bit            wr_idle = 1'b1;
    bit            fin = 1'b0;

    neopixel_frame_sequencer #(.NUM_PIXELS(NP)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pixel_addr (pixel_addr),
      .pixel_data (pixel_data),
      .bit_value  (bit_value),
      .bit_valid  (bit_valid),
      .bit_busy   (bit_busy),
      .frame_busy (frame_busy),
      .frame_done (frame_done)
    );

    // synchronous-read colour RAM, data one clk after the address
    always @(posedge clk) pixel_data <= ram[pixel_addr];

    // bit writer: acknowledges each strobe a little later and holds busy for a while
    initial begin
      int hold;
      forever begin
        @(negedge clk);
        if (bit_valid && !rst) begin
          repeat ($urandom_range(3, 1)) @(negedge clk);
          bit_busy = 1'b1;
          wr_idle  = 1'b0;
          hold = long_mode ? 500 : int'($urandom_range(6, 1));
          repeat (hold) @(negedge clk);
          bit_busy  = 1'b0;
          last_fall = cyc;
          wr_idle   = 1'b1;
        end
      end
    end

    // monitor: pops the scoreboard on every strobe and checks frame-level rules
    initial begin
      bit prev_val = 1'b0;
      bit e;
      forever begin
        @(negedge clk);
        if (rst) begin
          prev_val = 1'b0;
        end else begin
          if (bit_valid) begin
            chk(NP, "valid_expected", longint'(exp_q.size() > 0), 1);
            chk(NP, "valid_while_busy", longint'(bit_busy), 0);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk(NP, "bit_value", longint'(bit_value), longint'(e));
              chk(NP, "pixel_addr", longint'(pixel_addr), vcount / CW);
              if (vcount % CW == 5) ram[vcount / CW] = CW'($urandom);
              vcount++;
            end
          end else begin
            chk(NP, "bit_value_stable", longint'(bit_value), longint'(prev_val));
          end
          prev_val = bit_value;
          if (frame_done) begin
            chk(NP, "done_expected", longint'(pending > 0), 1);
            chk(NP, "bits_per_frame", vcount, NP * CW);
            chk(NP, "latch_latency", cyc - last_fall, LATCH_CYC + 1);
            chk(NP, "busy_at_done", longint'(frame_busy), 0);
            if (pending > 0) pending--;
          end else begin
            chk(NP, "frame_busy", longint'(frame_busy), longint'(pending > 0));
          end
        end
      end
    end

    task automatic accept();
      vcount = 0;
      for (int p = 0; p < NP; p++)
        for (int b = CW - 1; b >= 0; b--)
          exp_q.push_back(ram[p][b]);
      pending++;
    endtask

    task automatic send_frame();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      accept();
    endtask

    task automatic spurious_start();
      repeat ($urandom_range(400, 50)) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    endtask

    // returns 1 time unit after the edge that raised frame_done
    task automatic wait_done_edge();
      for (int i = 0; i < 60000; i++) begin
        @(posedge clk); #1;
        if (frame_done) return;
      end
      chk(NP, "done_timeout", 0, 1);
    endtask

    task automatic randomize_ram();
      for (int p = 0; p < NP; p++) ram[p] = CW'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
      chk(NP, {tag, "_pixel_addr"}, longint'(pixel_addr), 0);
      chk(NP, {tag, "_bit_value"},  longint'(bit_value), 0);
      chk(NP, {tag, "_bit_valid"},  longint'(bit_valid), 0);
      chk(NP, {tag, "_frame_busy"}, longint'(frame_busy), 0);
      chk(NP, {tag, "_frame_done"}, longint'(frame_done), 0);
    endtask

    initial begin
      int target;
      int i;
      for (int p = 0; p < NP; p++)
        ram[p] = (NP == 2) ? ((p == 0) ? 24'hFF0000 : 24'h00000F) : 24'hAAAAAA;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);

      // fixed pattern frame, stray start mid-frame, lone start in the DONE cycle
      send_frame();
      spurious_start();
      wait_done_edge();
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);

      // slow writer, then a start straddling DONE and IDLE
      randomize_ram();
      long_mode = 1'b1;
      send_frame();
      spurious_start();
      wait_done_edge();
      long_mode = 1'b0;
      randomize_ram();
      start = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 start = 1'b0;
      accept();
      wait_done_edge();
      repeat (5) @(posedge clk);

      // reset in the middle of a frame
      randomize_ram();
      send_frame();
      target = (NP > 1) ? 34 : 10;
      for (i = 0; i < 20000 && vcount < target; i++) @(negedge clk);
      if (i == 20000) chk(NP, "reset_point_timeout", vcount, target);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      exp_q.delete();
      pending = 0;
      vcount  = 0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      repeat (10) @(negedge clk);
      for (i = 0; i < 2000 && !wr_idle; i++) @(negedge clk);
      if (i == 2000) chk(NP, "writer_idle_timeout", longint'(wr_idle), 1);

      // fresh frames restart from pixel 0
      for (int f = 0; f < 2; f++) begin
        randomize_ram();
        send_frame();
        wait_done_edge();
        repeat (3) @(posedge clk);
      end
      fin = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 95000; i++) begin
      if (u[0].fin && u[1].fin) break;
      @(posedge clk);
    end
    if (!(u[0].fin && u[1].fin)) chk(0, "run_timeout", 0, 1);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
